// File: rtl/serial_deser_4.sv
// Serial-to-parallel deserializer: assembles LSB-first bits into 4-bit words
// and holds each completed word in a single-entry output register with sticky overrun.
module serial_deser_4 (
    input  logic       clk,
    input  logic       clear,
    input  logic       s_in,
    input  logic       s_valid,
    input  logic       word_ready,
    output logic [3:0] word_out,
    output logic       word_valid,
    output logic [1:0] bit_cnt,
    output logic [7:0] word_cnt,
    output logic       overrun
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_sh;
    logic [1:0]  r_bit_cnt;
    logic [3:0]  r_word_out;
    logic [7:0]  r_word_cnt;
    logic        r_overrun;

    logic        w_complete;
    logic [3:0]  w_word;
    logic        w_load;
    logic        w_drop;

    assign w_complete = s_valid && (r_bit_cnt == 2'd3);
    assign w_word     = {s_in, r_sh[3:1]};

    // Holding-register FSM: decide next state and whether a completed word loads or drops.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_state_next = ST_FULL;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    w_state_next = ST_FULL;
                    if (word_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (word_ready) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Assembly shift register and bit counter; gaps in s_valid simply hold the partial word.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sh      <= 4'b0000;
            r_bit_cnt <= 2'd0;
        end else if (s_valid) begin
            r_sh      <= w_word;
            r_bit_cnt <= r_bit_cnt + 2'd1;
        end else begin
            r_sh      <= r_sh;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Output word, delivered-word counter (free-running wrap) and sticky overrun.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_word_out <= 4'b0000;
            r_word_cnt <= 8'd0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_word_out <= w_word;
                r_word_cnt <= r_word_cnt + 8'd1;
            end else begin
                r_word_out <= r_word_out;
                r_word_cnt <= r_word_cnt;
            end
            r_overrun <= r_overrun | w_drop;
        end
    end

    assign word_out   = r_word_out;
    assign word_valid = (r_state == ST_FULL);
    assign bit_cnt    = r_bit_cnt;
    assign word_cnt   = r_word_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deser_4.sv
// Self-checking bench for serial_deser_4: vector table, directed corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_serial_deser_4;

    logic       clk;
    logic       clear;
    logic       s_in;
    logic       s_valid;
    logic       word_ready;
    logic [3:0] word_out;
    logic       word_valid;
    logic [1:0] bit_cnt;
    logic [7:0] word_cnt;
    logic       overrun;

    int n_vec;
    int n_bad;

    serial_deser_4 dut (
        .clk        (clk),
        .clear      (clear),
        .s_in       (s_in),
        .s_valid    (s_valid),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .bit_cnt    (bit_cnt),
        .word_cnt   (word_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic       si;
        logic       rdy;
        logic [3:0] wo;
        logic       wv;
        logic [1:0] bc;
        logic [7:0] wc;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic sv, input logic si, input logic rdy,
                                input logic [3:0] wo, input logic wv, input logic [1:0] bc,
                                input logic [7:0] wc, input logic ov);
        vec_t v;
        v.sv = sv; v.si = si; v.rdy = rdy;
        v.wo = wo; v.wv = wv; v.bc = bc; v.wc = wc; v.ov = ov;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] wo, input logic wv,
                         input logic [1:0] bc, input logic [7:0] wc, input logic ov);
        logic [15:0] got;
        logic [15:0] exp;
        got = {word_out, word_valid, bit_cnt, word_cnt, overrun};
        exp = {wo, wv, bc, wc, ov};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got wo=%b wv=%b bc=%0d wc=%0d ov=%b, expected wo=%b wv=%b bc=%0d wc=%0d ov=%b",
                     name, word_out, word_valid, bit_cnt, word_cnt, overrun, wo, wv, bc, wc, ov);
        end
    endtask

    // Drive one cycle's inputs, let the edge pass, sample 1 time unit later.
    task automatic step(input logic sv, input logic si, input logic rdy);
        s_valid    = sv;
        s_in       = si;
        word_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clear = 1'b0;
    endtask

    // Reference model state (plain integers).
    int m_pcnt, m_pval, m_held, m_cnt;
    bit m_full, m_ovr;

    task automatic model_reset();
        m_pcnt = 0; m_pval = 0; m_held = 0; m_cnt = 0; m_full = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit clr, input bit sv, input bit si, input bit rdy);
        bit complete;
        int word;
        if (clr) begin
            model_reset();
        end else begin
            complete = sv && (m_pcnt == 3);
            word     = m_pval + (si ? 8 : 0);
            if (sv) begin
                if (m_pcnt == 3) begin
                    m_pcnt = 0; m_pval = 0;
                end else begin
                    m_pval = m_pval + (si ? (1 << m_pcnt) : 0);
                    m_pcnt = m_pcnt + 1;
                end
            end
            if (m_full) begin
                if (complete) begin
                    if (rdy) begin
                        m_held = word; m_cnt = (m_cnt + 1) % 256;
                    end else begin
                        m_ovr = 1;
                    end
                end else if (rdy) begin
                    m_full = 0;
                end
            end else if (complete) begin
                m_full = 1; m_held = word; m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] last_word;
        n_vec = 0;
        n_bad = 0;
        clear = 1'b1; s_in = 1'b0; s_valid = 1'b0; word_ready = 1'b0;

        // Reset state
        step(1'b1, 1'b1, 1'b1);
        check("reset", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
        clear = 1'b0;

        // Word 1,0,1,1 -> 1101; then overrun with 0,0,0,1; release; gapped 0,1,1,0 -> 0110
        add(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 8'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b1101, 1'b1, 2'd0, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b1101, 1'b1, 2'd1, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b1101, 1'b1, 2'd2, 8'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b1101, 1'b1, 2'd3, 8'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b1101, 1'b1, 2'd0, 8'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 2'd0, 8'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 2'd0, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 2'd1, 8'd1, 1'b1);
        for (int g = 0; g < 3; g++) add(1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 2'd1, 8'd1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 2'd2, 8'd1, 1'b1);
        for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 2'd2, 8'd1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 2'd3, 8'd1, 1'b1);
        for (int g = 0; g < 3; g++) add(1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 2'd3, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 2'd0, 8'd2, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].sv, tbl[i].si, tbl[i].rdy);
            check($sformatf("table[%0d]", i), tbl[i].wo, tbl[i].wv, tbl[i].bc, tbl[i].wc, tbl[i].ov);
        end

        // Load while FULL with ready on the completing edge
        do_reset();
        check("clear_after_table", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        check("full_0011", 4'b0011, 1'b1, 2'd0, 8'd1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        check("full_partial", 4'b0011, 1'b1, 2'd3, 8'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("full_reload_1111", 4'b1111, 1'b1, 2'd0, 8'd2, 1'b0);

        // Asynchronous clear mid-word while FULL
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        check("pre_async_clear", 4'b1111, 1'b1, 2'd2, 8'd2, 1'b0);
        s_valid = 1'b0;
        #3 clear = 1'b1;
        #1 check("async_clear", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
        #1 clear = 1'b0;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        check("post_clear_0001", 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);

        // 256 words with ready held high: counter wraps to zero
        do_reset();
        last_word = 4'b0000;
        for (int w = 0; w < 256; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic bit_v;
                bit_v = 1'($urandom_range(0, 1));
                last_word[b] = bit_v;
                step(1'b1, bit_v, 1'b1);
            end
            if (w == 254) check("wrap_255", last_word, 1'b1, 2'd0, 8'd255, 1'b0);
        end
        check("wrap_000", last_word, 1'b1, 2'd0, 8'd0, 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            bit r_clr, r_sv, r_si, r_rdy;
            r_clr = ($urandom_range(0, 199) == 0);
            r_sv  = ($urandom_range(0, 3) != 0);
            r_si  = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 2) == 0);
            clear = r_clr;
            step(r_sv, r_si, r_rdy);
            clear = 1'b0;
            model_edge(r_clr, r_sv, r_si, r_rdy);
            check($sformatf("random[%0d]", c), 4'(m_held), m_full, 2'(m_pcnt), 8'(m_cnt), m_ovr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_deser_4.md
SERIAL_DESER_4 -- requirements
Module: serial_deser_4

Interface
REQ-001 Parameters: none; word width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 clear  input  1  reset, asynchronous, active-high; SHALL force reset state immediately, independent of clk.
REQ-004 s_in  input  1  serial data bit from the upstream right-shift stage's serial output; LSB arrives first.
REQ-005 s_valid  input  1  high = s_in carries a valid bit this cycle; mirrors the upstream shift-enable.
REQ-006 word_out  output  4  assembled parallel word held for the consumer.
REQ-007 word_valid  output  1  high = word_out holds an unconsumed word.
REQ-008 word_ready  input  1  consumer accepts word_out on a posedge where word_valid && word_ready.
REQ-009 bit_cnt  output  2  number of bits of the partial word captured so far (0-3).
REQ-010 word_cnt  output  8  count of words delivered to the holding register; wraps 255 -> 0.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 Assembly register sh[3:0]: on posedge with s_valid=1, sh SHALL become {s_in, sh[3:1]} and bit_cnt SHALL increment modulo 4.
REQ-013 With s_valid=0, sh and bit_cnt SHALL hold; gaps of any length between bits SHALL NOT abort a partial word.
REQ-014 Word completion: a posedge with s_valid=1 and bit_cnt=3 completes a word whose value is {s_in, sh[3:1]}; bit_cnt SHALL return to 0 on that edge.
REQ-015 Output FSM states: EMPTY (word_valid=0) and FULL (word_valid=1); word_valid SHALL be a direct decode of the state.
REQ-016 EMPTY + completion -> FULL; word_out SHALL load the completed word on the same edge (zero-cycle latency from the 4th bit edge); word_cnt SHALL increment.
REQ-017 FULL + (word_ready=1) without completion -> EMPTY; word_out SHALL hold its last value.
REQ-018 FULL + word_ready=1 + completion on the same edge -> stay FULL; word_out SHALL load the new word; word_cnt SHALL increment; overrun SHALL NOT set.
REQ-019 FULL + word_ready=0 + completion -> stay FULL; word_out SHALL keep the old word; the new word SHALL be discarded; overrun SHALL set to 1; word_cnt SHALL NOT increment.
REQ-020 overrun SHALL remain 1 until clear; no other input SHALL clear it.
REQ-021 word_out SHALL change only on a load edge (REQ-016/018); word_ready with word_valid=0 SHALL have no effect.
REQ-022 word_cnt SHALL wrap from 8'hFF to 8'h00 with no flag.

Reset
REQ-023 While clear=1: sh=4'b0000, bit_cnt=0, word_out=4'b0000, state=EMPTY (word_valid=0), word_cnt=0, overrun=0.
REQ-024 clear asserted mid-word or while FULL SHALL discard the partial word and the held word; no word SHALL be delivered from pre-reset bits.
REQ-025 First posedge after clear deasserts SHALL operate normally; a bit presented with s_valid=1 on that edge SHALL be captured as bit 0.

Verification
REQ-026 Reset, then s_valid=1 with s_in=1,0,1,1 on 4 consecutive edges -> after 4th edge word_out=4'b1101, word_valid=1, bit_cnt=0, word_cnt=1.
REQ-027 Bits 0,1,1,0 delivered with 3-cycle s_valid=0 gaps between each, word_ready=1 -> word_out=4'b0110 after 4th valid bit; bit_cnt holds during gaps (1, 2, 3).
REQ-028 FULL with 4'b1101, word_ready=0, send 0,0,0,1 -> word_out stays 4'b1101, overrun=1, word_cnt unchanged; then word_ready=1 one edge -> word_valid=0, overrun stays 1.
REQ-029 FULL with 4'b0011, word_ready=1 held on the edge completing 1,1,1,1 -> word_valid stays 1, word_out=4'b1111, overrun=0, word_cnt +1.
REQ-030 Assert clear asynchronously (between edges) after 2 bits of a word and with word_valid=1 -> all outputs to REQ-023 values immediately; next 4 bits 1,0,0,0 -> word_out=4'b0001.
REQ-031 Deliver 256 words with word_ready=1 -> word_cnt wraps to 8'h00, overrun=0.
